// File: rtl/req_resp_pkg.sv
// req_resp_pkg: shared widths and FSM state encoding for req_responder
package req_resp_pkg;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    typedef enum logic [1:0] {IDLE = 2'b00, WAIT = 2'b01, ACK = 2'b10} state_e;
endpackage

// File: rtl/req_responder_if.sv
// req_responder_if: request/ack bus (req, we, addr, wdata -> ack, rdata, busy)
interface req_responder_if;
    import req_resp_pkg::*;
    logic req;
    logic we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic ack;
    logic [DATA_W-1:0] rdata;
    logic busy;
    modport master (output req, we, addr, wdata, input ack, rdata, busy);
    modport slave (input req, we, addr, wdata, output ack, rdata, busy);
endinterface

// File: rtl/resp_regfile.sv
// resp_regfile: DEPTHx8 storage, sync write, comb read, sync clear on reset
module resp_regfile
    import req_resp_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (reset) mem <= '{default: '0};
        else if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/req_responder.sv
// req_responder: captures a request, waits LATENCY cycles, then acks once (clk, reset, bus slave)
module req_responder
    import req_resp_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 16
) (
    input logic            clk,
    input logic            reset,
    req_responder_if.slave bus
);
    state_e state, state_n;
    logic [3:0] cnt;
    logic cap_we;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;
    logic [DATA_W-1:0] mem_rdata;
    always_ff @(posedge clk)
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && bus.req) begin
                cnt       <= 4'(LATENCY - 1);
                cap_we    <= bus.we;
                cap_addr  <= bus.addr;
                cap_wdata <= bus.wdata;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
        end
    // unlisted encodings fall through to the IDLE default
    always_comb begin
        state_n = IDLE;
        if (state == IDLE && bus.req) state_n = LATENCY > 0 ? WAIT : ACK;
        else if (state == WAIT) state_n = cnt == 4'd0 ? ACK : WAIT;
    end
    assign bus.ack   = state == ACK;
    assign bus.busy  = state == WAIT || state == ACK;
    assign bus.rdata = (state == ACK && !cap_we) ? mem_rdata : '0;
    resp_regfile #(.DEPTH(DEPTH)) u_regfile (
        .clk   (clk),
        .reset (reset),
        .we    (state == ACK && cap_we),
        .waddr (cap_addr),
        .wdata (cap_wdata),
        .raddr (cap_addr),
        .rdata (mem_rdata)
    );
endmodule

// File: doc/req_responder.md
REQ_RESPONDER -- requirements
Module: req_responder

Interface
REQ-001 Parameter LATENCY, default 2, number of wait cycles between request capture and ack (legal 0..15).
REQ-002 Parameter DEPTH, default 16, number of 8-bit storage words; fixed at 16 by ADDR_W=4.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 req  input  1  initiator request; held with we/addr/wdata until ack.
REQ-006 we  input  1  1 = write, 0 = read; valid while req=1.
REQ-007 addr  input  4  word address; valid while req=1.
REQ-008 wdata  input  8  write data; valid while req=1 and we=1.
REQ-009 ack  output  1  one-cycle completion pulse to the initiator.
REQ-010 rdata  output  8  read data; valid only in the ack cycle of a read.
REQ-011 busy  output  1  high while a transaction is captured and not yet acked.

Function
REQ-012 FSM states IDLE, WAIT, ACK; encoding IDLE=2'b00, WAIT=2'b01, ACK=2'b10; any other encoding SHALL return to IDLE next cycle.
REQ-013 IDLE: req=1 at a clock edge captures we, addr, wdata into internal registers; next state WAIT if LATENCY>0, else ACK.
REQ-014 On capture, the 4-bit wait counter loads LATENCY-1; WAIT decrements it each cycle and exits to ACK on the cycle it reads 0.
REQ-015 Ack latency: ack is high exactly LATENCY+1 cycles after the edge that sampled req=1 in IDLE.
REQ-016 ACK: ack=1 for exactly one cycle; next state IDLE unconditionally.
REQ-017 Write: the captured wdata is stored at the captured addr on the edge ending the ACK cycle.
REQ-018 Read: rdata = storage[captured addr] during the ACK cycle; rdata = 8'h00 in all other cycles.
REQ-019 busy = 1 in WAIT and ACK, 0 in IDLE.
REQ-020 Inputs are ignored outside IDLE; req deasserting or addr/wdata changing during WAIT/ACK does not alter the transaction in flight.
REQ-021 req still high in the cycle after ack (IDLE) is a new transaction; back-to-back period = LATENCY+2 cycles.
REQ-022 Read-after-write to the same address in back-to-back transactions returns the newly written value.
REQ-023 No error response exists; every captured request completes with exactly one ack.

Reset
REQ-024 reset=1 forces state IDLE, counter 0, captured registers 0, all 16 storage words 8'h00 on the same edge.
REQ-025 During and after reset: ack=0, rdata=8'h00, busy=0.
REQ-026 Reset in WAIT or ACK aborts the transaction: no ack is issued, no write is performed.
REQ-027 reset has priority over every other input.

Structure
REQ-028 Package req_resp_pkg SHALL hold state_e, ADDR_W=4, DATA_W=8.
REQ-029 Storage SHALL be a sub-module resp_regfile (16x8, synchronous write, combinational read, synchronous clear); FSM, counter and capture registers stay in req_responder.

Verification
REQ-030 Reset then idle 10 cycles -> ack=0, busy=0, rdata=8'h00 throughout.
REQ-031 LATENCY=2: write addr=4'h3 wdata=8'hA5 with req at edge N -> ack only at edge N+3; a following read of 4'h3 -> rdata=8'hA5 in its ack cycle.
REQ-032 LATENCY=0: req held high with alternating write 8'h5A to 4'hF / read of 4'hF -> ack every 2nd cycle, read returns 8'h5A.
REQ-033 Read of 4'h7 with req dropped and addr changed to 4'h0 during WAIT -> one ack, rdata = storage[4'h7].
REQ-034 Write 8'hFF to 4'h1 with reset asserted in WAIT -> no ack; subsequent read of 4'h1 returns 8'h00.
REQ-035 LATENCY=15: single read -> ack exactly 16 cycles after capture, busy high for 16 cycles.
